slide_intf: RTL

Round-robin sampler for the six equalizer slide potentiometers through an external SPI A2D converter. Each pot's 12-bit result is held in a register that drives the equalizer core's LP/B1/B2/B3/HP/VOL gain inputs. The block runs continuously after reset, needs no host handshake, and sits directly upstream of the core's band-scaling stage.

---
 rtl/eq_pkg.sv | 38 +++
 rtl/spi_mstr16.sv | 88 ++++++++
 rtl/slide_intf.sv | 83 ++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer slide-pot front end:
// slot order, A2D channel map, sequencer/SPI state encodings.
package eq_pkg;

  localparam int unsigned SPI_WORD_W = 16;
  localparam int unsigned POT_W      = 12;
  localparam int unsigned NUM_SLOTS  = 6;

  typedef enum logic [2:0] {
    SLOT_LP,
    SLOT_B1,
    SLOT_B2,
    SLOT_B3,
    SLOT_HP,
    SLOT_VOL
  } slot_e;

  // A2D channel wired to each slot, indexed by slot_e
  localparam logic [2:0] CH_MAP [NUM_SLOTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  typedef enum logic [1:0] {
    SEQ_CMD,
    SEQ_GAP,
    SEQ_READ,
    SEQ_STORE
  } seq_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SHIFT,
    SPI_BACKPORCH
  } spi_state_e;

  function automatic logic [SPI_WORD_W-1:0] cmd_word(input slot_e s);
    return {2'b00, CH_MAP[s], 11'h000};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Generic 16-bit SPI master, SCLK idles high, MOSI changes on SCLK fall,
// MISO sampled just before SCLK rise. One shared shift register for both.
module spi_mstr16
  import eq_pkg::*;
#(
  parameter int unsigned SCLK_DIV_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt,
  input  logic [SPI_WORD_W-1:0] cmd,
  output logic                  done,
  output logic [SPI_WORD_W-1:0] rd_data,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

  spi_state_e            state;
  logic [SCLK_DIV_W-1:0] div;
  logic [4:0]            bit_cnt;
  logic [SPI_WORD_W-1:0] shft;
  logic                  miso_smpl;
  logic                  rise_evt;
  logic                  fall_evt;

  assign rise_evt = (state != SPI_IDLE) && (div == DIV_RISE);
  assign fall_evt = (state != SPI_IDLE) && (div == DIV_FALL);

  assign SCLK    = div[SCLK_DIV_W-1];
  assign MOSI    = shft[SPI_WORD_W-1];
  assign rd_data = shft;

  // The first SCLK fall does not shift (MSB is already on MOSI); the 16th
  // shift happens at the would-be 17th fall, where SS_n releases instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SPI_IDLE;
      div       <= '1;
      bit_cnt   <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SPI_IDLE: begin
          if (wrt) begin
            div     <= DIV_LOAD;
            shft    <= cmd;
            bit_cnt <= '0;
            SS_n    <= 1'b0;
            state   <= SPI_SHIFT;
          end
        end
        SPI_SHIFT: begin
          div <= div + 1'b1;
          if (rise_evt) miso_smpl <= MISO;
          if (fall_evt) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt != '0) shft <= {shft[SPI_WORD_W-2:0], miso_smpl};
            if (bit_cnt == 5'd15) state <= SPI_BACKPORCH;
          end
        end
        SPI_BACKPORCH: begin
          if (rise_evt) miso_smpl <= MISO;
          if (fall_evt) begin
            shft  <= {shft[SPI_WORD_W-2:0], miso_smpl};
            div   <= '1;
            SS_n  <= 1'b1;
            done  <= 1'b1;
            state <= SPI_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/slide_intf.sv
// Round-robin sampler of the six EQ slide pots through an SPI A2D:
// command transaction, one-cycle gap, read transaction, store.
module slide_intf
  import eq_pkg::*;
#(
  parameter int unsigned SCLK_DIV_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic [POT_W-1:0] LP_pot,
  output logic [POT_W-1:0] B1_pot,
  output logic [POT_W-1:0] B2_pot,
  output logic [POT_W-1:0] B3_pot,
  output logic [POT_W-1:0] HP_pot,
  output logic [POT_W-1:0] VOL_pot
);

  seq_state_e            state;
  slot_e                 slot;
  logic                  wrt_sent;
  logic                  wrt;
  logic                  done;
  logic [SPI_WORD_W-1:0] cmd;
  logic [SPI_WORD_W-1:0] rd_data;
  logic                  rd_hi_unused;
  logic [POT_W-1:0]      pot_q [NUM_SLOTS];

  assign wrt          = ((state == SEQ_CMD) || (state == SEQ_READ)) && !wrt_sent;
  assign cmd          = (state == SEQ_CMD) ? cmd_word(slot) : '0;
  assign rd_hi_unused = ^rd_data[SPI_WORD_W-1:POT_W];

  spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEQ_CMD;
      slot     <= SLOT_LP;
      wrt_sent <= 1'b0;
      pot_q    <= '{default: '0};
    end else begin
      case (state)
        SEQ_CMD, SEQ_READ: begin
          if (wrt) begin
            wrt_sent <= 1'b1;
          end else if (done) begin
            wrt_sent <= 1'b0;
            state    <= (state == SEQ_CMD) ? SEQ_GAP : SEQ_STORE;
          end
        end
        SEQ_GAP: state <= SEQ_READ;
        SEQ_STORE: begin
          pot_q[slot] <= rd_data[POT_W-1:0];
          slot        <= (slot == SLOT_VOL) ? SLOT_LP : slot_e'(slot + 3'd1);
          state       <= SEQ_CMD;
        end
        default: state <= SEQ_CMD;
      endcase
    end
  end

  assign LP_pot  = pot_q[SLOT_LP];
  assign B1_pot  = pot_q[SLOT_B1];
  assign B2_pot  = pot_q[SLOT_B2];
  assign B3_pot  = pot_q[SLOT_B3];
  assign HP_pot  = pot_q[SLOT_HP];
  assign VOL_pot = pot_q[SLOT_VOL];

endmodule
